// File: rtl/motor_output_stage.sv
// H-bridge output stage with dead-time insertion on direction changes, a per-channel
// encoder stall watchdog and a write-1-to-clear fault status register on the peripheral bus.
module motor_output_stage #(
   parameter logic [7:0]  STATUS_ADDRESS = 8'h06,
   parameter int unsigned DEAD_CYCLES    = 1600,
   parameter int unsigned STALL_CYCLES   = 8000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic [7:0] address,
   input  logic       w_en,
   input  logic       r_en,
   output logic [7:0] dout,
   input  logic [3:0] motor_in,
   input  logic [1:0] pwm_in,
   input  logic       enable_in,
   input  logic [1:0] encoders,
   output logic [3:0] motor_out,
   output logic [1:0] pwm_out,
   output logic       enable_out
);
   localparam int unsigned NUM_CH  = 2;
   localparam int unsigned DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam int unsigned STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

   localparam logic [DEAD_W-1:0]  DEAD_LOAD  = DEAD_W'(DEAD_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

   localparam logic [1:0] ST_COAST = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DEAD  = 2'd2;

   logic [1:0] fault;
   logic [1:0] enc_s1;
   logic [1:0] enc_s2;
   logic [1:0] enc_d;
   logic [1:0] enc_edge_c;
   logic [1:0] stall_trip_c;
   logic [1:0] fault_clr_c;
   logic       status_hit_c;
   logic       unused_din_c;

   assign status_hit_c = (address == STATUS_ADDRESS);
   assign fault_clr_c  = (w_en && status_hit_c) ? din[1:0] : 2'b00;
   assign enc_edge_c   = enc_d ^ enc_s2;
   assign unused_din_c = ^din[7:2];

   // Encoder synchronizers, fault register (a stall set beats a same-cycle clear) and bus read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_s1     <= 2'b00;
         enc_s2     <= 2'b00;
         enc_d      <= 2'b00;
         fault      <= 2'b00;
         enable_out <= 1'b0;
         dout       <= 8'h00;
      end else begin
         enc_s1     <= encoders;
         enc_s2     <= enc_s1;
         enc_d      <= enc_s2;
         fault      <= (fault & ~fault_clr_c) | stall_trip_c;
         enable_out <= enable_in;
         dout       <= (r_en && status_hit_c) ? {6'b000000, fault} : 8'h00;
      end
   end

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [1:0]         code;
      logic [1:0]         state;
      logic [1:0]         state_nxt;
      logic [1:0]         cur;
      logic [1:0]         cur_nxt;
      logic [1:0]         pend;
      logic [1:0]         pend_nxt;
      logic [DEAD_W-1:0]  cnt;
      logic [DEAD_W-1:0]  cnt_nxt;
      logic [STALL_W-1:0] stall_cnt;
      logic               stall_run_c;
      logic               trip_c;
      logic [1:0]         motor_q;
      logic               pwm_q;

      assign code = motor_in[2*ch +: 2];

      // State and output registers; outputs follow the next state so a drive shows one cycle after the request.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state   <= ST_COAST;
            cur     <= 2'b00;
            pend    <= 2'b00;
            cnt     <= '0;
            motor_q <= 2'b00;
            pwm_q   <= 1'b0;
         end else begin
            state   <= state_nxt;
            cur     <= cur_nxt;
            pend    <= pend_nxt;
            cnt     <= cnt_nxt;
            motor_q <= (state_nxt == ST_DRIVE) ? cur_nxt : 2'b00;
            pwm_q   <= (state_nxt == ST_DRIVE) && pwm_in[ch];
         end
      end

      always_comb begin
         state_nxt = state;
         cur_nxt   = cur;
         pend_nxt  = pend;
         cnt_nxt   = cnt;
         if (fault[ch]) begin
            state_nxt = ST_COAST;
         end else begin
            case (state)
               ST_COAST: begin
                  if (code != 2'b00) begin
                     state_nxt = ST_DRIVE;
                     cur_nxt   = code;
                  end
               end
               ST_DRIVE: begin
                  if (code == 2'b00) begin
                     state_nxt = ST_COAST;
                  end else if (code != cur) begin
                     state_nxt = ST_DEAD;
                     pend_nxt  = code;
                     cnt_nxt   = DEAD_LOAD;
                  end
               end
               ST_DEAD: begin
                  if (code == 2'b00) begin
                     state_nxt = ST_COAST;
                  end else if (code != pend) begin
                     pend_nxt = code;
                     cnt_nxt  = DEAD_LOAD;
                  end else if (cnt == '0) begin
                     state_nxt = ST_DRIVE;
                     cur_nxt   = pend;
                  end else begin
                     cnt_nxt = cnt - DEAD_W'(1);
                  end
               end
               default: state_nxt = ST_COAST;
            endcase
         end
      end

      // Brake never runs the watchdog; only fwd/rev with the driver enabled can stall.
      assign stall_run_c = (state == ST_DRIVE) && ((cur == 2'b01) || (cur == 2'b10)) && enable_in;
      assign trip_c      = stall_run_c && !enc_edge_c[ch] && (stall_cnt == STALL_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stall_cnt <= '0;
         end else if (!stall_run_c || enc_edge_c[ch] || trip_c) begin
            stall_cnt <= '0;
         end else begin
            stall_cnt <= stall_cnt + STALL_W'(1);
         end
      end
   end

   assign motor_out    = {g_ch[1].motor_q, g_ch[0].motor_q};
   assign pwm_out      = {g_ch[1].pwm_q, g_ch[0].pwm_q};
   assign stall_trip_c = {g_ch[1].trip_c, g_ch[0].trip_c};

endmodule

// File: tb/tb_motor_output_stage.sv
// Directed bench for motor_output_stage with short dead-time and stall windows.
module tb_motor_output_stage;
   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic [7:0] address;
   logic       w_en;
   logic       r_en;
   logic [7:0] dout;
   logic [3:0] motor_in;
   logic [1:0] pwm_in;
   logic       enable_in;
   logic [1:0] encoders;
   logic [3:0] motor_out;
   logic [1:0] pwm_out;
   logic       enable_out;

   int checks;
   int failures;

   motor_output_stage #(
      .STATUS_ADDRESS(8'h06),
      .DEAD_CYCLES   (4),
      .STALL_CYCLES  (20)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .address   (address),
      .w_en      (w_en),
      .r_en      (r_en),
      .dout      (dout),
      .motor_in  (motor_in),
      .pwm_in    (pwm_in),
      .enable_in (enable_in),
      .encoders  (encoders),
      .motor_out (motor_out),
      .pwm_out   (pwm_out),
      .enable_out(enable_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
      motor_in = 4'h0; pwm_in = 2'b00; enable_in = 1'b0; encoders = 2'b00;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({motor_out, pwm_out, enable_out, dout} !== 15'h0000) begin
         failures++;
         $display("FAIL reset_outputs: got motor=%b pwm=%b en=%b dout=%h, expected all zero",
                  motor_out, pwm_out, enable_out, dout);
      end
      step(2);
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_enable();
      enable_in = 1'b1;
      checks++;
      if (enable_out !== 1'b0) begin
         failures++;
         $display("FAIL enable_latency_pre: got %b expected 0", enable_out);
      end
      step(1);
      checks++;
      if (enable_out !== 1'b1) begin
         failures++;
         $display("FAIL enable_follow: got %b expected 1", enable_out);
      end
      enable_in = 1'b0;
      step(1);
      checks++;
      if (enable_out !== 1'b0) begin
         failures++;
         $display("FAIL enable_drop: got %b expected 0", enable_out);
      end
   endtask

   task automatic test_dead_time();
      pwm_in = 2'b01;
      motor_in = 4'b0001;
      step(1);
      checks++;
      if (motor_out !== 4'b0001 || pwm_out !== 2'b01) begin
         failures++;
         $display("FAIL dead_enter_drive: got motor=%b pwm=%b expected 0001/01", motor_out, pwm_out);
      end
      step(1);
      motor_in = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         step(1);
         checks++;
         if (motor_out[1:0] !== 2'b00 || pwm_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL dead_window[%0d]: got motor=%b pwm=%b expected 00/0", i, motor_out[1:0], pwm_out[0]);
         end
      end
      step(1);
      checks++;
      if (motor_out[1:0] !== 2'b10 || pwm_out[0] !== 1'b1) begin
         failures++;
         $display("FAIL dead_exit: got motor=%b pwm=%b expected 10/1", motor_out[1:0], pwm_out[0]);
      end
      motor_in = 4'b0000;
      step(1);
      checks++;
      if (motor_out !== 4'b0000) begin
         failures++;
         $display("FAIL dead_to_coast: got %b expected 0000", motor_out);
      end
   endtask

   task automatic test_pwm_passthrough();
      logic [7:0] pat;
      pat = 8'b1011_0010;
      motor_in = 4'b0001;
      pwm_in = {1'b1, pat[0]};
      step(1);
      checks++;
      if (motor_out !== 4'b0001 || pwm_out !== {1'b0, pat[0]}) begin
         failures++;
         $display("FAIL pwm_first: got motor=%b pwm=%b expected 0001/%b", motor_out, pwm_out, {1'b0, pat[0]});
      end
      for (int i = 1; i < 8; i++) begin
         pwm_in[0] = pat[i];
         step(1);
         checks++;
         if (pwm_out !== {1'b0, pat[i]}) begin
            failures++;
            $display("FAIL pwm_follow[%0d]: got %b expected %b", i, pwm_out, {1'b0, pat[i]});
         end
      end
      motor_in = 4'b0000;
      pwm_in = 2'b00;
      step(1);
   endtask

   task automatic test_dead_restart();
      int zeros;
      zeros = 0;
      pwm_in = 2'b01;
      motor_in = 4'b0001;
      step(2);
      motor_in = 4'b0010;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) motor_in = 4'b0001;
         step(1);
         if (motor_out[1:0] === 2'b00 && pwm_out[0] === 1'b0) zeros++;
      end
      checks++;
      if (zeros !== 6) begin
         failures++;
         $display("FAIL restart_window: got %0d coast cycles expected 6", zeros);
      end
      step(1);
      checks++;
      if (motor_out[1:0] !== 2'b01) begin
         failures++;
         $display("FAIL restart_exit: got %b expected 01", motor_out[1:0]);
      end
      motor_in = 4'b0000;
      pwm_in = 2'b00;
      step(1);
   endtask

   task automatic test_stall_fault();
      enable_in = 1'b1;
      motor_in = 4'b1000;
      r_en = 1'b1;
      address = 8'h06;
      step(1);
      checks++;
      if (motor_out !== 4'b1000) begin
         failures++;
         $display("FAIL stall_drive: got %b expected 1000", motor_out);
      end
      step(20);
      checks++;
      if (dout !== 8'h00 || motor_out !== 4'b1000) begin
         failures++;
         $display("FAIL stall_early: got dout=%h motor=%b expected 00/1000", dout, motor_out);
      end
      step(1);
      checks++;
      if (dout !== 8'h02 || motor_out !== 4'b0000 || enable_out !== 1'b1) begin
         failures++;
         $display("FAIL stall_trip: got dout=%h motor=%b en=%b expected 02/0000/1", dout, motor_out, enable_out);
      end
      address = 8'h05;
      step(1);
      checks++;
      if (dout !== 8'h00) begin
         failures++;
         $display("FAIL other_addr_read: got %h expected 00", dout);
      end
      r_en = 1'b0; w_en = 1'b1; din = 8'hFF;
      step(1);
      address = 8'h06; din = 8'h01;
      step(1);
      w_en = 1'b0; r_en = 1'b1;
      step(1);
      checks++;
      if (dout !== 8'h02) begin
         failures++;
         $display("FAIL w1c_wrong_bits: got %h expected 02", dout);
      end
      r_en = 1'b0; w_en = 1'b1; din = 8'h02;
      step(1);
      w_en = 1'b0;
      step(1);
      checks++;
      if (motor_out[3:2] !== 2'b10) begin
         failures++;
         $display("FAIL clear_redrive: got %b expected 10", motor_out[3:2]);
      end
      r_en = 1'b1;
      step(1);
      checks++;
      if (dout !== 8'h00) begin
         failures++;
         $display("FAIL clear_status: got %h expected 00", dout);
      end
      motor_in = 4'b0000; r_en = 1'b0; enable_in = 1'b0;
      step(1);
   endtask

   task automatic test_set_wins();
      enable_in = 1'b1;
      motor_in = 4'b1000;
      address = 8'h06;
      step(1);
      step(19);
      w_en = 1'b1; din = 8'h02;
      step(1);
      w_en = 1'b0; r_en = 1'b1;
      step(1);
      checks++;
      if (dout !== 8'h02) begin
         failures++;
         $display("FAIL set_beats_clear: got %h expected 02", dout);
      end
      r_en = 1'b0; w_en = 1'b1;
      step(1);
      w_en = 1'b0; motor_in = 4'b0000; enable_in = 1'b0;
      step(1);
      r_en = 1'b1;
      step(1);
      checks++;
      if (dout !== 8'h00) begin
         failures++;
         $display("FAIL set_wins_cleanup: got %h expected 00", dout);
      end
      r_en = 1'b0;
   endtask

   task automatic test_encoder_no_stall();
      enable_in = 1'b1;
      motor_in = 4'b0001;
      for (int i = 0; i < 500; i++) begin
         if (i % 10 == 0) encoders[0] = ~encoders[0];
         step(1);
      end
      r_en = 1'b1; address = 8'h06;
      step(1);
      checks++;
      if (dout !== 8'h00 || motor_out !== 4'b0001) begin
         failures++;
         $display("FAIL encoder_keepalive: got dout=%h motor=%b expected 00/0001", dout, motor_out);
      end
      motor_in = 4'b0000; enable_in = 1'b0; r_en = 1'b0; encoders = 2'b00;
      step(4);
   endtask

   task automatic test_reset_mid_dead();
      enable_in = 1'b1;
      pwm_in = 2'b11;
      motor_in = 4'b0001;
      step(25);
      r_en = 1'b1; address = 8'h06;
      motor_in = 4'b0101;
      step(1);
      motor_in = 4'b1001;
      step(2);
      checks++;
      if (dout !== 8'h01 || enable_out !== 1'b1 || motor_out !== 4'b0000) begin
         failures++;
         $display("FAIL pre_reset_setup: got dout=%h en=%b motor=%b expected 01/1/0000", dout, enable_out, motor_out);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({motor_out, pwm_out, enable_out, dout} !== 15'h0000) begin
         failures++;
         $display("FAIL async_reset: got motor=%b pwm=%b en=%b dout=%h expected all zero",
                  motor_out, pwm_out, enable_out, dout);
      end
      motor_in = 4'b0000; enable_in = 1'b0; pwm_in = 2'b00;
      step(2);
      rst_n = 1'b1;
      step(1);
      checks++;
      if (dout !== 8'h00) begin
         failures++;
         $display("FAIL post_reset_status: got %h expected 00", dout);
      end
      r_en = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_enable();
      test_dead_time();
      test_pwm_passthrough();
      test_dead_restart();
      test_stall_fault();
      test_set_wins();
      test_encoder_no_stall();
      test_reset_mid_dead();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
